pic_cascade_sequencer: RTL and testbench
========================================

# pic_cascade_sequencer

Parametrised cascade and interrupt-acknowledge sequencer for the 8259A-compatible PIC. Tracks the two-pulse 8086-mode INTA sequence on a single clock. As master it drives the selected slave ID onto the cascade bus; as slave it matches the bus against its own ID and returns its vector on the data bus. It sits between the priority resolver/ISR logic and the data-bus buffer, and includes a watchdog on the inter-pulse gap.

## Interface
- CAS_W, 3, cascade bus width; 2**CAS_W interrupt levels / cascade ports
- VEC_W, 8, data-bus/vector width (VEC_W > CAS_W)
- TIMEOUT, 64, max clk cycles allowed in GAP before abort (≥1)
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- master_mode  input  1  1 = master, 0 = slave; sampled at ACK1 entry
- icw3  input  2**CAS_W  master: slave-present mask per IR; slave: bits [CAS_W-1:0] = own ID
- vector_base  input  VEC_W  ICW2; bits [VEC_W-1:CAS_W] used
- int_req  input  1  resolver has a pending unmasked request
- irq_level  input  CAS_W  highest-priority pending level
- inta_n  input  1  raw INTA, active low, asynchronous to clk
- cas_in  input  CAS_W  cascade bus as seen at the pins
- cas_out  output  CAS_W  cascade bus drive value
- cas_oe  output  1  cascade bus drive enable
- data_out  output  VEC_W  vector
- data_oe  output  1  data bus drive enable
- isr_set  output  1  one-cycle pulse: set ISR bit isr_level
- isr_level  output  CAS_W  level to set / being serviced
- ack_done  output  1  one-cycle pulse at end of second INTA
- seq_err  output  1  one-cycle pulse on gap timeout

## Operation
- inta_n is passed through a 2-flop synchroniser (reset to 1). fall/rise are detected from the synchroniser output against one further registered copy.
- States: IDLE, ACK1, GAP, ACK2.
  - IDLE -fall-> ACK1
  - ACK1 -rise-> GAP
  - GAP -fall-> ACK2
  - ACK2 -rise-> IDLE (pulse ack_done)
  - A rise in IDLE and a fall in ACK1/ACK2 are ignored.
- ACK1 entry:
  - mode_q <= master_mode.
  - Master:
    - If int_req=1: lvl_q <= irq_level, casc_q <= icw3[irq_level], and isr_set pulses.
    - If int_req=0 (spurious): lvl_q <= all-ones (IR7), casc_q <= 0, no isr_set.
- Master cascade drive: cas_oe = casc_q and cas_out = lvl_q from ACK1 entry until IDLE is re-entered.
- Slave, ACK1 exit (rise):
  - sel_q <= (cas_in == icw3[CAS_W-1:0]).
  - If sel_q is set, isr_set pulses with isr_level = irq_level, and lvl_q <= irq_level.
- ACK2 entry:
  - data_out <= {vector_base[VEC_W-1:CAS_W], lvl_q}.
  - data_oe <= (master & ~casc_q) | (slave & sel_q).
- IDLE entry: cas_oe, data_oe, casc_q and sel_q are cleared in the same cycle. data_out holds its last value.
- isr_level is a registered copy of lvl_q.
- Counter arithmetic: gap counter width $clog2(TIMEOUT+1). It clears on GAP entry and saturates at TIMEOUT.

## Timing
- Reset (asynchronous, immediate, including mid-sequence):
  - state = IDLE.
  - All outputs = 0 (cas_out, cas_oe, data_out, data_oe, isr_set, isr_level, ack_done, seq_err).
  - Synchroniser flops = 1.
  - Gap counter = 0.
- Latency: inta_n sampled low at edge k gives the state transition and registered output update at edge k+3. The same 3-cycle latency applies to rise.
- isr_set, ack_done and seq_err are exactly one cycle wide.
- cas_oe is stable from ACK1 entry through ACK2 exit, with no glitch in GAP.
- Minimum INTA low/high width for detection: 3 clk periods. Narrower pulses may be missed and are not errors.
- Timeout at the GAP/fall boundary: if the counter reaches TIMEOUT and a fall is detected in the same cycle, the fall wins (go to ACK2).

## Configuration
- PIC_CASCADE_TIMEOUT_EN defined:
  - The gap counter is compiled in.
  - When GAP has lasted TIMEOUT cycles, go to IDLE, release cas_oe/data_oe, and pulse seq_err.
  - No isr_set undo occurs.
- Not defined:
  - No counter is built. GAP waits indefinitely.
  - seq_err is tied to 0.

## Test plan
- Master, icw3=8'h00, vector_base=8'h40, int_req=1, irq_level=5, two INTA pulses -> isr_set with isr_level=5 after ACK1, cas_oe=0, data_oe=1 with data_out=8'h45 in ACK2, ack_done after the second rise.
- Master, icw3=8'h04, irq_level=2 -> cas_oe=1 and cas_out=3'd2 from ACK1 through ACK2, data_oe stays 0, cas_oe=0 on IDLE.
- Slave, icw3[2:0]=3'd2, cas_in=3'd2, vector_base=8'h70, irq_level=1 -> isr_set at first rise, data_oe=1 with data_out=8'h71 in ACK2. Repeat with cas_in=3'd3 -> no isr_set, data_oe stays 0.
- Master, int_req=0 at first INTA, vector_base=8'h08 -> no isr_set, data_out=8'h0F in ACK2.
- With PIC_CASCADE_TIMEOUT_EN, TIMEOUT=16, one INTA pulse only, cas_oe=1 -> seq_err pulse when GAP has lasted 16 cycles, cas_oe=0, a subsequent INTA pulse starts a fresh ACK1.
- Assert rst_n=0 during ACK2 with data_oe=1 -> data_oe, cas_oe and data_out go to 0 immediately, state IDLE. After release, a full sequence completes normally.

Source files
------------

// File: rtl/pic_cascade_sequencer.sv
// pic_cascade_sequencer
//
// Cascade and interrupt-acknowledge sequencer for an 8259A-compatible PIC.
// It follows the two-pulse 8086-mode INTA sequence on a single clock.
// As master it drives the selected slave ID onto the cascade bus.
// As slave it matches the cascade bus against its own ID and returns its vector.
//
// Optional feature: define PIC_CASCADE_TIMEOUT_EN to build the inter-pulse gap
// watchdog. Without it, GAP waits indefinitely and seq_err is tied to 0.
//
// Ports:
//   clk, rst_n   system clock (rising edge); asynchronous active-low reset
//   master_mode  1 = master, 0 = slave; sampled on ACK1 entry
//   icw3         master: slave-present mask per IR; slave: [CAS_W-1:0] = own ID
//   vector_base  ICW2; only bits [VEC_W-1:CAS_W] are used
//   int_req      resolver has a pending unmasked request
//   irq_level    highest-priority pending level
//   inta_n       raw INTA, active low, asynchronous to clk
//   cas_in       cascade bus as seen at the pins
//   cas_out      cascade bus drive value
//   cas_oe       cascade bus drive enable
//   data_out     vector byte
//   data_oe      data bus drive enable
//   isr_set      one-cycle pulse: set the ISR bit isr_level
//   isr_level    level to set / being serviced
//   ack_done     one-cycle pulse at the end of the second INTA
//   seq_err      one-cycle pulse on gap timeout
module pic_cascade_sequencer #(
  parameter int unsigned CAS_W   = 3,
  parameter int unsigned VEC_W   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  master_mode,
  input  logic [2**CAS_W-1:0]   icw3,
  input  logic [VEC_W-1:0]      vector_base,
  input  logic                  int_req,
  input  logic [CAS_W-1:0]      irq_level,
  input  logic                  inta_n,
  input  logic [CAS_W-1:0]      cas_in,
  output logic [CAS_W-1:0]      cas_out,
  output logic                  cas_oe,
  output logic [VEC_W-1:0]      data_out,
  output logic                  data_oe,
  output logic                  isr_set,
  output logic [CAS_W-1:0]      isr_level,
  output logic                  ack_done,
  output logic                  seq_err
);

  typedef enum logic [1:0] {StIdle, StAck1, StGap, StAck2} state_e;

  state_e             state_q;
  logic               inta_s1_q, inta_s2_q, inta_d_q;
  logic               fall_q, rise_q;
  logic               mode_q;
  logic [CAS_W-1:0]   lvl_q;
  logic [CAS_W-1:0]   cas_out_q;
  logic               casc_q;
  logic               sel_q;
  logic [VEC_W-1:0]   data_out_q;
  logic               data_oe_q;
  logic               isr_set_q;
  logic               ack_done_q;
  logic               slave_match;

  assign slave_match = (cas_in == icw3[CAS_W-1:0]);

  // Low vector bits come from the serviced level, not from ICW2.
  logic unused_vec_low;
  assign unused_vec_low = ^vector_base[CAS_W-1:0];

  // Two-flop synchroniser, then one more copy for edge detection. The edge
  // pulses are registered, so pin-to-state latency is three edges after capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_s1_q <= 1'b1;
      inta_s2_q <= 1'b1;
      inta_d_q  <= 1'b1;
      fall_q    <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      inta_s1_q <= inta_n;
      inta_s2_q <= inta_s1_q;
      inta_d_q  <= inta_s2_q;
      fall_q    <= inta_d_q & ~inta_s2_q;
      rise_q    <= ~inta_d_q & inta_s2_q;
    end
  end

`ifdef PIC_CASCADE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] gap_cnt_q;
  logic            seq_err_q;
  logic            gap_expire;

  // The counter reaches TIMEOUT on the edge that leaves GAP, so GAP lasts
  // exactly TIMEOUT cycles. A simultaneous fall still takes priority.
  assign gap_expire = (gap_cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_q <= '0;
    end else if (state_q == StAck1 && rise_q) begin
      gap_cnt_q <= '0;
    end else if (state_q == StGap && gap_cnt_q != CntW'(TIMEOUT)) begin
      gap_cnt_q <= gap_cnt_q + 1'b1;
    end
  end

  assign seq_err = seq_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign seq_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      lvl_q      <= '0;
      cas_out_q  <= '0;
      casc_q     <= 1'b0;
      sel_q      <= 1'b0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      isr_set_q  <= 1'b0;
      ack_done_q <= 1'b0;
`ifdef PIC_CASCADE_TIMEOUT_EN
      seq_err_q  <= 1'b0;
`endif
    end else begin
      isr_set_q  <= 1'b0;
      ack_done_q <= 1'b0;
`ifdef PIC_CASCADE_TIMEOUT_EN
      seq_err_q  <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (fall_q) begin
            state_q <= StAck1;
            mode_q  <= master_mode;
            if (master_mode) begin
              if (int_req) begin
                lvl_q     <= irq_level;
                cas_out_q <= irq_level;
                casc_q    <= icw3[irq_level];
                isr_set_q <= 1'b1;
              end else begin
                // Spurious request: answer with IR7 and keep the cascade bus idle.
                lvl_q     <= '1;
                cas_out_q <= '1;
                casc_q    <= 1'b0;
              end
            end
          end
        end
        StAck1: begin
          if (rise_q) begin
            state_q <= StGap;
            if (!mode_q) begin
              sel_q <= slave_match;
              if (slave_match) begin
                lvl_q     <= irq_level;
                isr_set_q <= 1'b1;
              end
            end
          end
        end
        StGap: begin
          if (fall_q) begin
            state_q    <= StAck2;
            data_out_q <= {vector_base[VEC_W-1:CAS_W], lvl_q};
            data_oe_q  <= mode_q ? ~casc_q : sel_q;
          end
`ifdef PIC_CASCADE_TIMEOUT_EN
          else if (gap_expire) begin
            state_q   <= StIdle;
            cas_out_q <= '0;
            casc_q    <= 1'b0;
            sel_q     <= 1'b0;
            data_oe_q <= 1'b0;
            seq_err_q <= 1'b1;
          end
`endif
        end
        StAck2: begin
          if (rise_q) begin
            state_q    <= StIdle;
            cas_out_q  <= '0;
            casc_q     <= 1'b0;
            sel_q      <= 1'b0;
            data_oe_q  <= 1'b0;
            ack_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cas_out   = cas_out_q;
  assign cas_oe    = casc_q;
  assign data_out  = data_out_q;
  assign data_oe   = data_oe_q;
  assign isr_set   = isr_set_q;
  assign isr_level = lvl_q;
  assign ack_done  = ack_done_q;

endmodule

// File: tb/tb_pic_cascade_sequencer.sv
// Self-checking bench for pic_cascade_sequencer (CAS_W=3, VEC_W=8, TIMEOUT=16).
module tb_pic_cascade_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       master_mode;
  logic [7:0] icw3;
  logic [7:0] vector_base;
  logic       int_req;
  logic [2:0] irq_level;
  logic       inta_n;
  logic [2:0] cas_in;
  logic [2:0] cas_out;
  logic       cas_oe;
  logic [7:0] data_out;
  logic       data_oe;
  logic       isr_set;
  logic [2:0] isr_level;
  logic       ack_done;
  logic       seq_err;

  pic_cascade_sequencer #(
    .CAS_W  (3),
    .VEC_W  (8),
    .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .master_mode(master_mode),
    .icw3       (icw3),
    .vector_base(vector_base),
    .int_req    (int_req),
    .irq_level  (irq_level),
    .inta_n     (inta_n),
    .cas_in     (cas_in),
    .cas_out    (cas_out),
    .cas_oe     (cas_oe),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .isr_set    (isr_set),
    .isr_level  (isr_level),
    .ack_done   (ack_done),
    .seq_err    (seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mm;
    logic [7:0] icw3;
    logic [7:0] vb;
    logic       req;
    logic [2:0] lvl;
    logic [2:0] cas;
    int         e_isr;
    logic [2:0] e_lvl;
    logic       e_cas_oe;
    logic [2:0] e_cas_out;
    logic       e_data_oe;
    logic [7:0] e_data_out;
  } vec_t;

  vec_t tv[7];

  int n_cmp  = 0;
  int n_fail = 0;

  // Per-sequence observations
  int         n_isr, n_ack, n_serr, isr_at, ack_at;
  logic [2:0] lvl_seen;
  logic       oe_a1, oe_gap, oe_a2, doe_a2, post_cas_oe, post_data_oe;
  logic [2:0] cout_gap;
  logic [7:0] dout_a2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    n_isr = 0; n_ack = 0; n_serr = 0; isr_at = -1; ack_at = -1;
    lvl_seen = '0; oe_a1 = 0; oe_gap = 0; oe_a2 = 0; doe_a2 = 0;
    cout_gap = '0; dout_a2 = '0; post_cas_oe = 0; post_data_oe = 0;
  endtask

  // Drive inta_n to lvl for n cycles; sample every negedge. Sample i is taken
  // after the i-th rising edge following the change of inta_n.
  task automatic phase(input logic lvl, input int n, input int ph);
    inta_n = lvl;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (isr_set) begin
        n_isr++;
        lvl_seen = isr_level;
        isr_at   = ph * 16 + i;
      end
      if (ack_done) begin
        n_ack++;
        ack_at = ph * 16 + i;
      end
      if (seq_err) n_serr++;
      if (ph == 0 && i == 5) oe_a1 = cas_oe;
      if (ph == 1 && i == n) begin
        oe_gap   = cas_oe;
        cout_gap = cas_out;
      end
      if (ph == 2 && i == n) begin
        oe_a2   = cas_oe;
        doe_a2  = data_oe;
        dout_a2 = data_out;
      end
      if (ph == 3 && i == n) begin
        post_cas_oe  = cas_oe;
        post_data_oe = data_oe;
      end
    end
  endtask

  task automatic set_inputs(input vec_t v);
    master_mode = v.mm;
    icw3        = v.icw3;
    vector_base = v.vb;
    int_req     = v.req;
    irq_level   = v.lvl;
    cas_in      = v.cas;
  endtask

  task automatic run_seq();
    clear_obs();
    phase(1'b0, 6, 0);
    phase(1'b1, 8, 1);
    phase(1'b0, 6, 2);
    phase(1'b1, 8, 3);
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    chk({tag, " isr_set count"}, n_isr, v.e_isr);
    if (v.e_isr != 0) begin
      chk({tag, " isr_level"}, lvl_seen, v.e_lvl);
      // master: ACK1 entry 3 edges after capture; slave: at ACK1 exit
      chk({tag, " isr_set timing"}, isr_at, v.mm ? 4 : 20);
    end
    chk({tag, " cas_oe ack1/gap/ack2"}, {oe_a1, oe_gap, oe_a2}, {3{v.e_cas_oe}});
    if (v.e_cas_oe) chk({tag, " cas_out"}, cout_gap, v.e_cas_out);
    chk({tag, " data_oe"}, doe_a2, v.e_data_oe);
    if (v.e_data_oe) chk({tag, " data_out"}, dout_a2, v.e_data_out);
    chk({tag, " ack_done count"}, n_ack, 1);
    chk({tag, " ack_done timing"}, ack_at, 52);
    chk({tag, " idle oe"}, {post_cas_oe, post_data_oe}, 2'b00);
    chk({tag, " seq_err"}, n_serr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1'b1, 8'h00, 8'h40, 1'b1, 3'd5, 3'd0, 1, 3'd5, 1'b0, 3'd0, 1'b1, 8'h45};
    tv[1] = '{1'b1, 8'h04, 8'h40, 1'b1, 3'd2, 3'd0, 1, 3'd2, 1'b1, 3'd2, 1'b0, 8'h00};
    tv[2] = '{1'b0, 8'h02, 8'h70, 1'b0, 3'd1, 3'd2, 1, 3'd1, 1'b0, 3'd0, 1'b1, 8'h71};
    tv[3] = '{1'b0, 8'h02, 8'h70, 1'b0, 3'd1, 3'd3, 0, 3'd0, 1'b0, 3'd0, 1'b0, 8'h00};
    tv[4] = '{1'b1, 8'h00, 8'h08, 1'b0, 3'd5, 3'd0, 0, 3'd0, 1'b0, 3'd0, 1'b1, 8'h0F};
    tv[5] = '{1'b1, 8'hFF, 8'h98, 1'b1, 3'd7, 3'd0, 1, 3'd7, 1'b1, 3'd7, 1'b0, 8'h00};
    tv[6] = '{1'b0, 8'h05, 8'hF8, 1'b1, 3'd6, 3'd5, 1, 3'd6, 1'b0, 3'd0, 1'b1, 8'hFE};

    rst_n = 1'b0;
    inta_n = 1'b1;
    set_inputs(tv[0]);
    repeat (3) @(negedge clk);
    chk("reset outputs",
        {cas_out, cas_oe, data_out, data_oe, isr_set, isr_level, ack_done, seq_err}, '0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      set_inputs(tv[k]);
      run_seq();
      check_vec(tv[k], $sformatf("vec%0d", k));
    end

    // Asynchronous reset in ACK2 while driving the data bus
    set_inputs(tv[0]);
    clear_obs();
    phase(1'b0, 6, 0);
    phase(1'b1, 8, 1);
    phase(1'b0, 6, 2);
    chk("pre-reset data_oe", data_oe, 1'b1);
    chk("pre-reset data_out", data_out, 8'h45);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset outputs", {data_oe, cas_oe, data_out, isr_level, ack_done}, '0);
    inta_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post-reset quiet", {cas_oe, data_oe, isr_set, ack_done}, '0);
    set_inputs(tv[1]);
    run_seq();
    check_vec(tv[1], "after reset");

    // One INTA pulse only, cascade bus driven during GAP
    set_inputs(tv[1]);
    clear_obs();
    phase(1'b0, 6, 0);
    begin
      int   first_err = -1;
      logic oe19 = 1'b0;
      logic oe_err = 1'b1;
      inta_n = 1'b1;
      for (int i = 1; i <= 40; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (seq_err) begin
          n_serr++;
          if (first_err < 0) begin
            first_err = i;
            oe_err    = cas_oe;
          end
        end
        if (i == 19) oe19 = cas_oe;
      end
`ifdef PIC_CASCADE_TIMEOUT_EN
      // GAP entered at sample 4, lasts 16 cycles: IDLE visible at sample 20
      chk("timeout seq_err timing", first_err, 20);
      chk("timeout seq_err width", n_serr, 1);
      chk("timeout cas_oe before", oe19, 1'b1);
      chk("timeout cas_oe released", oe_err, 1'b0);
      set_inputs(tv[0]);
      run_seq();
      check_vec(tv[0], "after timeout");
`else
      chk("no-timeout seq_err", n_serr, 0);
      chk("no-timeout cas_oe held", {oe19, cas_oe}, 2'b11);
      phase(1'b0, 6, 2);
      phase(1'b1, 8, 3);
      chk("late ack_done", n_ack, 1);
      chk("late data_oe", doe_a2, 1'b0);
      chk("late idle cas_oe", post_cas_oe, 1'b0);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
